// File: rtl/jpeg_out_fifo.sv
// Bus-mapped byte FIFO: BYTE/WORD stores push JPEG bytes, streamed out on a valid/ready port.
// Push-to-out_valid latency one cycle (no bypass); full FIFO drops whole stores and sets sticky overflow.
module jpeg_out_fifo #(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        sel,
    input  logic        wr_en,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] n_push;
    logic             byte_wr, word_wr, stat_wr, stat_rd;
    logic             byte_ok, word_ok, pop, flush;

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign stat_rd   = sel && (addr == 4'h8);
    assign rd_data   = stat_rd ? {overflow_q, 15'(free), 16'(count_q)} : 32'h0;

    always_comb begin
        free    = CNT_W'(DEPTH) - count_q;
        byte_wr = sel && wr_en && (addr == 4'h0);
        word_wr = sel && wr_en && (addr == 4'h4);
        stat_wr = sel && wr_en && (addr == 4'h8);
        // Space is judged on the pre-pop count, so a full FIFO rejects even when popping.
        byte_ok = byte_wr && (count_q < CNT_W'(DEPTH));
        word_ok = word_wr && (free >= CNT_W'(4));
        pop     = out_valid && out_ready;
        flush   = stat_wr && wdata[1];
        n_push  = byte_ok ? CNT_W'(1) : (word_ok ? CNT_W'(4) : '0);

        wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
        rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + PTR_W'(pop);
        count_d  = flush ? '0 : count_q + n_push - CNT_W'(pop);

        overflow_d = overflow_q;
        if (stat_wr && wdata[0])
            overflow_d = 1'b0;
        else if ((byte_wr && !byte_ok) || (word_wr && !word_ok))
            overflow_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is cleared on reset so out_data reads zero afterwards.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 8'h00;
        end else if (byte_ok) begin
            mem_q[wr_ptr_q] <= wdata[7:0];
        end else if (word_ok) begin
            for (int i = 0; i < 4; i++)
                mem_q[wr_ptr_q + PTR_W'(i)] <= wdata[31-8*i -: 8];
        end
    end
endmodule

// File: tb/tb_jpeg_out_fifo.sv
// Bench for jpeg_out_fifo: queue-based reference model checked every cycle, plus literal scenarios.
module tb_jpeg_out_fifo;
    logic        clock = 1'b0;
    logic        nreset, sel, wr_en, out_ready;
    logic [3:0]  addr;
    logic [31:0] wdata, rd_data;
    logic [7:0]  out_data;
    logic        out_valid;

    always #5 clock = ~clock;

    jpeg_out_fifo #(.DEPTH(16)) dut (
        .clock(clock), .nreset(nreset), .sel(sel), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 0;
    logic [7:0] mq[$];
    bit movf = 0;
    logic [7:0] dlog[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mstatus();
        return {movf, 15'(16 - mq.size()), 16'(mq.size())};
    endfunction

    // Reference model: FIFO as a queue, updated on each rising edge.
    always @(posedge clock) begin
        int  c0;
        bit  popm;
        if (!nreset) begin
            mq.delete();
            movf = 0;
        end else begin
            c0   = mq.size();
            popm = (c0 != 0) && out_ready;
            if (sel && wr_en && addr == 4'h8 && wdata[1])
                mq.delete();
            else if (popm)
                void'(mq.pop_front());
            if (sel && wr_en) begin
                case (addr)
                    4'h0: if (c0 < 16) mq.push_back(wdata[7:0]); else movf = 1;
                    4'h4: if (16 - c0 >= 4) begin
                              mq.push_back(wdata[31:24]);
                              mq.push_back(wdata[23:16]);
                              mq.push_back(wdata[15:8]);
                              mq.push_back(wdata[7:0]);
                          end else movf = 1;
                    4'h8: if (wdata[0]) movf = 0;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) chk("out_data", out_data, mq[0]);
            chk("rd_data", rd_data, (sel && addr == 4'h8) ? mstatus() : 32'h0);
            if (out_valid && out_ready && nreset) dlog.push_back(out_data);
        end
    end

    task automatic idle(input int n);
        sel = 0; wr_en = 0; addr = 4'h0; wdata = 32'h0;
        repeat (n) begin @(posedge clock); #2; end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        sel = 1; wr_en = 1; addr = a; wdata = d;
        @(posedge clock); #2;
        sel = 0; wr_en = 0; addr = 4'h0; wdata = 32'h0;
    endtask

    task automatic rd_status(input string nm, input logic [31:0] exp);
        sel = 1; wr_en = 0; addr = 4'h8;
        @(negedge clock);
        chk(nm, rd_data, exp);
        @(posedge clock); #2;
        sel = 0; addr = 4'h0;
    endtask

    task automatic check_log(input string nm, input logic [7:0] e[$]);
        chk({nm, "_len"}, dlog.size(), e.size());
        for (int k = 0; k < e.size() && k < dlog.size(); k++)
            chk({nm, "_byte"}, dlog[k], e[k]);
    endtask

    initial begin
        logic [7:0] e[$];
        logic [3:0] atab[4];
        atab[0] = 4'h0; atab[1] = 4'h4; atab[2] = 4'h8; atab[3] = 4'hC;
        nreset = 0; sel = 0; wr_en = 0; addr = 4'h0; wdata = 32'h0; out_ready = 0;
        repeat (2) @(posedge clock);
        #2; nreset = 1; chk_en = 1;

        // Reset state
        chk("t1_valid", out_valid, 1'b0);
        chk("t1_data", out_data, 8'h00);
        rd_status("t1_status", 32'h0010_0000);

        // WORD streams big-endian
        dlog.delete(); out_ready = 1;
        wr(4'h4, 32'hFFD8_FFE0);
        idle(6);
        e = '{8'hFF, 8'hD8, 8'hFF, 8'hE0};
        check_log("t2", e);
        rd_status("t2_status", 32'h0010_0000);

        // Fill to full, overflowing BYTE dropped
        out_ready = 0; dlog.delete();
        wr(4'h4, 32'h0011_2233); wr(4'h4, 32'h4455_6677);
        wr(4'h4, 32'h8899_AABB); wr(4'h4, 32'hCCDD_EEFF);
        wr(4'h0, 32'h0000_0055);
        rd_status("t3_full", 32'h8000_0010);
        out_ready = 1; idle(18); out_ready = 0;
        e.delete();
        for (int k = 0; k < 16; k++) e.push_back(8'(k * 17));
        check_log("t3", e);
        rd_status("t3_empty", 32'h8010_0000);
        wr(4'h8, 32'h1);

        // WORD rejected at count 13
        wr(4'h4, 32'h0102_0304); wr(4'h4, 32'h0506_0708); wr(4'h4, 32'h090A_0B0C);
        wr(4'h0, 32'h0000_000D);
        rd_status("t4_13", 32'h0003_000D);
        wr(4'h4, 32'hDEAD_BEEF);
        rd_status("t4_ovf", 32'h8003_000D);
        wr(4'h8, 32'h1);
        rd_status("t4_clr", 32'h0003_000D);
        wr(4'h8, 32'h2);
        rd_status("t4_flush", 32'h0010_0000);

        // Full + pop + BYTE push
        wr(4'h4, 32'hA0A1_A2A3); wr(4'h4, 32'hA4A5_A6A7);
        wr(4'h4, 32'hA8A9_AAAB); wr(4'h4, 32'hACAD_AEAF);
        rd_status("t5_full", 32'h0000_0010);
        out_ready = 1;
        wr(4'h0, 32'h0000_0077);
        out_ready = 0;
        rd_status("t5_after", 32'h8001_000F);
        wr(4'h8, 32'h3);
        rd_status("t5_flush", 32'h0010_0000);

        // Mid-stream reset
        for (int k = 0; k < 7; k++) wr(4'h0, 32'(k + 8'h30));
        rd_status("t6_seven", 32'h0009_0007);
        nreset = 0; @(posedge clock); #2; nreset = 1;
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_data", out_data, 8'h00);
        rd_status("t6_status", 32'h0010_0000);

        // Pointer wrap across three 12-byte fills
        for (int f = 0; f < 3; f++) begin
            dlog.delete(); e.delete(); out_ready = 0;
            for (int j = 0; j < 3; j++)
                wr(4'h4, {8'(f*48 + 4*j), 8'(f*48 + 4*j + 1), 8'(f*48 + 4*j + 2), 8'(f*48 + 4*j + 3)});
            out_ready = 1; idle(14); out_ready = 0;
            for (int k = 0; k < 12; k++) e.push_back(8'(f*48 + k));
            check_log("t6_wrap", e);
        end

        // Randomized traffic against the model
        repeat (3000) begin
            out_ready = 1'($urandom_range(0, 1));
            nreset    = ($urandom_range(0, 199) != 0);
            sel       = ($urandom_range(0, 3) != 0);
            wr_en     = 1'($urandom_range(0, 1));
            addr      = atab[$urandom_range(0, 3)];
            wdata     = $urandom;
            if (addr == 4'h8 && $urandom_range(0, 7) != 0) wdata[1] = 1'b0;
            @(posedge clock); #2;
        end
        nreset = 1; out_ready = 1;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
